fme_pair_feeder: RTL and testbench

- Producer side of the FME half-pel averager interface.
- Accepts a raster-ordered integer-pel reference window, one pixel per cycle, over a valid/ready handshake.
- Emits registered neighbour pairs (x,y) for each averager instance:
  - horizontal pair: left, current
  - vertical pair: above, current
- A one-row line buffer supplies the "above" pixel.

---
 rtl/fme_pair_feeder.sv | 149 ++++++++++++++
 tb/tb_fme_pair_feeder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fme_pair_feeder.sv
// Producer side of the FME half-pel averager: turns a raster pixel stream into
// registered horizontal (left,current) and vertical (above,current) pairs.
module fme_pair_feeder #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int PIX_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [PIX_W-1:0]          pix_in,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic                      out_ready,
  output logic                      h_valid,
  output logic [PIX_W-1:0]          h_x,
  output logic [PIX_W-1:0]          h_y,
  output logic                      v_valid,
  output logic [PIX_W-1:0]          v_x,
  output logic [PIX_W-1:0]          v_y,
  output logic                      frame_done,
  output logic [$clog2(WIDTH)-1:0]  col_idx,
  output logic [$clog2(HEIGHT)-1:0] row_idx
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  logic             h_valid_q, h_valid_d;
  logic             v_valid_q, v_valid_d;
  logic [PIX_W-1:0] h_x_q, h_x_d, h_y_q, h_y_d;
  logic [PIX_W-1:0] v_x_q, v_x_d, v_y_q, v_y_d;
  logic             frame_done_q, frame_done_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PIX_W-1:0] left_q, left_d;
  logic [PIX_W-1:0] linebuf_q [WIDTH];

  logic             pending_s;
  logic             ready_s;
  logic             accept_s;
  logic [CW-1:0]    cur_col_s;
  logic [RW-1:0]    cur_row_s;
  logic [PIX_W-1:0] above_s;

  // Handshake and effective position; frame_start re-targets an accept to (0,0).
  always_comb begin
    pending_s = h_valid_q | v_valid_q;
    ready_s   = ~pending_s | out_ready;
    accept_s  = pix_valid & ready_s;
    if (frame_start) begin
      cur_col_s = '0;
      cur_row_s = '0;
    end else begin
      cur_col_s = col_q;
      cur_row_s = row_q;
    end
    above_s = linebuf_q[cur_col_s];
  end

  // Next-state for the pair registers, position counters and left pixel.
  always_comb begin
    h_valid_d    = h_valid_q;
    v_valid_d    = v_valid_q;
    h_x_d        = h_x_q;
    h_y_d        = h_y_q;
    v_x_d        = v_x_q;
    v_y_d        = v_y_q;
    frame_done_d = 1'b0;
    col_d        = cur_col_s;
    row_d        = cur_row_s;
    left_d       = left_q;
    if (accept_s) begin
      h_valid_d = (cur_col_s != '0);
      h_x_d     = left_q;
      h_y_d     = pix_in;
      v_valid_d = (cur_row_s != '0);
      v_x_d     = above_s;
      v_y_d     = pix_in;
      left_d    = pix_in;
      if (cur_col_s == LAST_COL) begin
        col_d = '0;
        if (cur_row_s == LAST_ROW) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = cur_row_s + RW'(1);
        end
      end else begin
        col_d = cur_col_s + CW'(1);
      end
    end else if (out_ready) begin
      // Drained with nothing new: drop valids, keep data fields.
      h_valid_d = 1'b0;
      v_valid_d = 1'b0;
    end else begin
      h_valid_d = h_valid_q;
      v_valid_d = v_valid_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid_q    <= 1'b0;
      v_valid_q    <= 1'b0;
      h_x_q        <= '0;
      h_y_q        <= '0;
      v_x_q        <= '0;
      v_y_q        <= '0;
      frame_done_q <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      left_q       <= '0;
    end else begin
      h_valid_q    <= h_valid_d;
      v_valid_q    <= v_valid_d;
      h_x_q        <= h_x_d;
      h_y_q        <= h_y_d;
      v_x_q        <= v_x_d;
      v_y_q        <= v_y_d;
      frame_done_q <= frame_done_d;
      col_q        <= col_d;
      row_q        <= row_d;
      left_q       <= left_d;
    end
  end

  // Line buffer is never cleared: row 0 never reads it.
  always_ff @(posedge clk) begin
    if (accept_s && !rst) begin
      linebuf_q[cur_col_s] <= pix_in;
    end
  end

  assign pix_ready  = ready_s;
  assign h_valid    = h_valid_q;
  assign h_x        = h_x_q;
  assign h_y        = h_y_q;
  assign v_valid    = v_valid_q;
  assign v_x        = v_x_q;
  assign v_y        = v_y_q;
  assign frame_done = frame_done_q;
  assign col_idx    = col_q;
  assign row_idx    = row_q;

endmodule

// File: tb/tb_fme_pair_feeder.sv
// Scoreboard bench for fme_pair_feeder: a window-level reference model pushes the
// expected output state per cycle; a monitor pops and compares after each edge.
module tb_fme_pair_feeder;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic [PW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic          out_ready = 1'b1;
  logic          h_valid, v_valid, frame_done;
  logic [PW-1:0] h_x, h_y, v_x, v_y;
  logic [1:0]    col_idx, row_idx;

  always #5 clk = ~clk;

  fme_pair_feeder #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .out_ready(out_ready),
    .h_valid(h_valid), .h_x(h_x), .h_y(h_y), .v_valid(v_valid), .v_x(v_x),
    .v_y(v_y), .frame_done(frame_done), .col_idx(col_idx), .row_idx(row_idx)
  );

  typedef struct packed {
    logic          hv;
    logic          vv;
    logic          fd;
    logic [PW-1:0] hx;
    logic [PW-1:0] hy;
    logic [PW-1:0] vx;
    logic [PW-1:0] vy;
    logic [1:0]    col;
    logic [1:0]    row;
  } out_t;

  out_t          expq[$];
  int            checks = 0;
  int            passed = 0;
  int            fd_exp = 0;
  int            fd_seen = 0;

  // Reference model: linear position in the window, the window itself, last pixel.
  out_t          m = '0;
  int            k = 0;
  logic [PW-1:0] prev = '0;
  logic [PW-1:0] img [H][W];

  task automatic step(input logic r, input logic fs, input logic pv,
                      input logic [PW-1:0] p, input logic ordy, output logic acc);
    logic rdy;
    int   rr, cc;
    @(negedge clk);
    rst = r; frame_start = fs; pix_valid = pv; pix_in = p; out_ready = ordy;
    #1;
    rdy = !(m.hv | m.vv) | ordy;
    checks++;
    if (pix_ready === rdy) passed++;
    else $display("FAIL pix_ready: got %b expected %b at %0t", pix_ready, rdy, $time);
    acc = 1'b0;
    if (r) begin
      m = '0; k = 0; prev = '0;
    end else begin
      if (fs) k = 0;
      acc  = pv & rdy;
      m.fd = 1'b0;
      if (acc) begin
        rr = k / W; cc = k % W;
        img[rr][cc] = p;
        m.hv = (cc != 0); m.hx = prev; m.hy = p;
        m.vv = (rr != 0); m.vx = (rr != 0) ? img[rr-1][cc] : '0; m.vy = p;
        prev = p;
        if (k == W*H-1) begin m.fd = 1'b1; fd_exp++; end
        k = (k + 1) % (W*H);
      end else if (ordy) begin
        m.hv = 1'b0; m.vv = 1'b0;
      end
    end
    m.col = 2'(k % W);
    m.row = 2'(k / W);
    expq.push_back(m);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1, a);
  endtask

  task automatic do_reset(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1, a);
  endtask

  // Offer pixel p; hold out_ready low for 'stall' cycles first, then drain.
  task automatic send_px(input logic [PW-1:0] p, input logic fs, input int stall);
    logic a;
    a = 1'b0;
    for (int i = 0; i < stall && !a; i++) step(1'b0, fs, 1'b1, p, 1'b0, a);
    if (!a) step(1'b0, fs, 1'b1, p, 1'b1, a);
  endtask

  // Stream the first n pixels of a window valued base+16r+c.
  task automatic stream(input int base, input int gap_at, input int stall_at, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) idle(1);
      send_px(PW'(base + 16*(i/W) + (i%W)), 1'b0, (i == stall_at) ? 3 : 0);
    end
  endtask

  // Monitor: compare the registered outputs against the queued expectation.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #2;
      if (frame_done === 1'b1) fd_seen++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        if (h_valid === e.hv && v_valid === e.vv && frame_done === e.fd &&
            h_x === e.hx && h_y === e.hy && v_y === e.vy &&
            (!e.vv || v_x === e.vx) && col_idx === e.col && row_idx === e.row)
          passed++;
        else
          $display("FAIL outputs @%0t: got hv=%b vv=%b fd=%b h=(%h,%h) v=(%h,%h) col=%0d row=%0d; expected hv=%b vv=%b fd=%b h=(%h,%h) v=(%h,%h) col=%0d row=%0d",
                   $time, h_valid, v_valid, frame_done, h_x, h_y, v_x, v_y, col_idx, row_idx,
                   e.hv, e.vv, e.fd, e.hx, e.hy, e.vx, e.vy, e.col, e.row);
      end
    end
  end

  initial begin
    logic a;
    int   n;
    do_reset(2);
    // Plain window, then a stall after (1,1), then a valid gap before (1,2).
    stream(0, -1, -1, 12);
    idle(1);
    stream(0, -1, 6, 12);
    stream(0, 6, -1, 12);
    // frame_start together with a pixel after (1,2).
    stream(0, -1, -1, 7);
    send_px(8'hAA, 1'b1, 0);
    send_px(8'hBB, 1'b0, 0);
    idle(1);
    // Reset after (2,1), then resume.
    do_reset(1);
    stream(0, -1, -1, 10);
    do_reset(1);
    send_px(8'h55, 1'b0, 0);
    send_px(8'h56, 1'b0, 0);
    // Two windows back-to-back.
    do_reset(1);
    stream(0, -1, -1, 12);
    stream(100, -1, -1, 12);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) != 0), PW'($urandom), ($urandom_range(0, 3) != 0), a);
    end
    idle(2);
    n = 0;
    while (expq.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (expq.size() == 0) passed++;
    else $display("FAIL drain: %0d expectations left, required 0", expq.size());
    checks++;
    if (fd_seen == fd_exp) passed++;
    else $display("FAIL frame_done_count: got %0d expected %0d", fd_seen, fd_exp);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
